// File: rtl/sfifo_pkg.sv
// Shared helpers for the pointer-based synchronous FIFO controller.
// The width helpers size the address and occupancy ports from the depth.
package sfifo_pkg;

  // Smallest legal depth; a one-entry FIFO has no use for pointers.
  localparam int MIN_DEPTH = 2;

  // Bits needed to hold the values 0..n inclusive (occupancy counter width).
  function automatic int clog2p1(input int n);
    int w;
    w = 0;
    while ((1 << w) <= n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Bits needed to index n entries (0..n-1), never less than one.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfifo_ptr_ctrl_wrap_ctr.sv
// Index counter that wraps from N-1 back to 0.
// The explicit wrap keeps non-power-of-2 depths correct.
module wrap_ctr
  import sfifo_pkg::*;
#(
  parameter int N = 2,
  localparam int W = addr_width(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Clear has priority; otherwise advance and wrap at the last entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/sfifo_ptr_ctrl.sv
// Pointer-based synchronous FIFO controller for an external array.
// Produces write/read indices, occupancy and almost-full/empty flags
// between a rdy/ack producer and consumer, with flush and an optional
// full-bypass that lets a full FIFO accept a push alongside a pop.
module sfifo_ptr_ctrl
  import sfifo_pkg::*;
#(
  parameter int NDATA     = 2,
  parameter int AFULL     = NDATA - 1,
  parameter int AEMPTY    = 1,
  parameter bit PASS_FULL = 1'b0,
  localparam int AW = addr_width(NDATA),
  localparam int CW = clog2p1(NDATA)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          src_rdy,
  output logic          src_ack,
  output logic          dst_rdy,
  input  logic          dst_ack,
  input  logic          i_flush,
  output logic          o_wen,
  output logic [AW-1:0] o_waddr,
  output logic          o_ren,
  output logic [AW-1:0] o_raddr,
  output logic [CW-1:0] o_count,
  output logic          o_afull,
  output logic          o_aempty
);

  localparam logic [CW-1:0] FULL_C   = CW'(NDATA);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY);

  if (NDATA < MIN_DEPTH || AFULL > NDATA || AEMPTY >= NDATA) begin : g_bad_params
    $error("sfifo_ptr_ctrl: illegal NDATA/AFULL/AEMPTY combination");
  end

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Handshake decode; flush masks both sides, bypass only when full and popping.
  always_comb begin
    full    = (count == FULL_C);
    empty   = (count == '0);
    dst_rdy = !empty && !i_flush;
    pop     = dst_ack && dst_rdy;
    push    = src_rdy && !i_flush && (!full || (PASS_FULL && pop));
    src_ack = push;
    o_wen   = push;
    o_ren   = pop;
  end

  wrap_ctr #(.N(NDATA)) u_wptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (push),
    .clr   (i_flush),
    .value (o_waddr)
  );

  wrap_ctr #(.N(NDATA)) u_rptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (pop),
    .clr   (i_flush),
    .value (o_raddr)
  );

  // Occupancy moves only on a lone push or a lone pop; flush empties it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  // Flags decode only the count register so they carry no handshake paths.
  always_comb begin
    o_count  = count;
    o_afull  = (count >= AFULL_C);
    o_aempty = (count <= AEMPTY_C);
  end

endmodule

// File: tb/tb_sfifo_ptr_ctrl.sv
// Self-checking bench for sfifo_ptr_ctrl (NDATA=5, AFULL=4, AEMPTY=1).
// dut_a uses PASS_FULL=0, dut_b uses PASS_FULL=1 for the full-bypass case.
module tb_sfifo_ptr_ctrl;
  import sfifo_pkg::*;

  localparam int NDATA  = 5;
  localparam int AFULL  = 4;
  localparam int AEMPTY = 1;
  localparam int AW     = addr_width(NDATA);
  localparam int CW     = clog2p1(NDATA);

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          src_rdy = 1'b0, dst_ack = 1'b0, i_flush = 1'b0;
  logic          src_ack, dst_rdy, o_wen, o_ren, o_afull, o_aempty;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [CW-1:0] o_count;

  logic          src_rdy_b = 1'b0, dst_ack_b = 1'b0, flush_b = 1'b0;
  logic          src_ack_b, dst_rdy_b, wen_b, ren_b, afull_b, aempty_b;
  logic [AW-1:0] waddr_b, raddr_b;
  logic [CW-1:0] count_b;

  sfifo_ptr_ctrl #(.NDATA(NDATA), .AFULL(AFULL), .AEMPTY(AEMPTY), .PASS_FULL(1'b0)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .src_rdy(src_rdy), .src_ack(src_ack),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .i_flush(i_flush), .o_wen(o_wen),
    .o_waddr(o_waddr), .o_ren(o_ren), .o_raddr(o_raddr), .o_count(o_count),
    .o_afull(o_afull), .o_aempty(o_aempty)
  );

  sfifo_ptr_ctrl #(.NDATA(NDATA), .AFULL(AFULL), .AEMPTY(AEMPTY), .PASS_FULL(1'b1)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .src_rdy(src_rdy_b), .src_ack(src_ack_b),
    .dst_rdy(dst_rdy_b), .dst_ack(dst_ack_b), .i_flush(flush_b), .o_wen(wen_b),
    .o_waddr(waddr_b), .o_ren(ren_b), .o_raddr(raddr_b), .o_count(count_b),
    .o_afull(afull_b), .o_aempty(aempty_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: a tag is queued for each accepted push and must come back in order on pops
  int sb_q[$];
  int mem [0:(1<<AW)-1];
  int next_tag = 0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      sb_q.delete();
    end else begin
      if (dst_ack && !dst_rdy && !i_flush)
        $display("[TB] protocol note: dst_ack while dst_rdy=0 at t=%0t", $time);
      if (o_ren) begin
        if (sb_q.size() == 0) checkOutput("sb_pop_on_empty", 1, 0);
        else checkOutput("sb_data", mem[o_raddr], sb_q.pop_front());
      end
      if (o_wen) begin
        mem[o_waddr] = next_tag;
        sb_q.push_back(next_tag);
        next_tag++;
      end
      if (i_flush) sb_q.delete();
    end
  end

  typedef struct {
    bit do_rst;
    bit sr, da, fl;
    int exp_sack, exp_drdy, exp_ren, exp_waddr, exp_raddr, exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input bit sr, input bit da, input bit fl,
                              input int sa, input int dr, input int rn,
                              input int wa, input int ra, input int cnt);
    vec_t v;
    v.do_rst = r; v.sr = sr; v.da = da; v.fl = fl;
    v.exp_sack = sa; v.exp_drdy = dr; v.exp_ren = rn;
    v.exp_waddr = wa; v.exp_raddr = ra; v.exp_count = cnt;
    return v;
  endfunction

  task automatic doReset();
    @(posedge i_clk);
    #1;
    src_rdy = 1'b0; dst_ack = 1'b0; i_flush = 1'b0;
    src_rdy_b = 1'b0; dst_ack_b = 1'b0; flush_b = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit sr, input bit da, input bit fl);
    @(posedge i_clk);
    #1;
    src_rdy = sr; dst_ack = da; i_flush = fl;
    @(negedge i_clk);
  endtask

  task automatic applyStimB(input bit sr, input bit da);
    @(posedge i_clk);
    #1;
    src_rdy_b = sr; dst_ack_b = da;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Test 1: fill from reset, sixth request refused
    vecs.push_back(mk(1, 1,0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 1,0,1));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 2,0,2));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 3,0,3));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 4,0,4));
    vecs.push_back(mk(0, 1,0,0, 0,1,0, 0,0,5));
    // Test 2: drain with 7 pop requests, last two on an empty FIFO
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 0,0,5));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 0,1,4));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 0,2,3));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 0,3,2));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 0,4,1));
    vecs.push_back(mk(0, 0,1,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0, 0,1,0, 0,0,0, 0,0,0));
    // Test 3: wrap - 3 push, 3 pop, 5 push, 3 pop
    vecs.push_back(mk(1, 1,0,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 1,0,1));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 2,0,2));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,0,3));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,1,2));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,2,1));
    vecs.push_back(mk(0, 1,0,0, 1,0,0, 3,3,0));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 4,3,1));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 0,3,2));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 1,3,3));
    vecs.push_back(mk(0, 1,0,0, 1,1,0, 2,3,4));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,3,5));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,4,4));
    vecs.push_back(mk(0, 0,1,0, 0,1,1, 3,0,3));

    $display("[TB] start");
    i_rst = 1'b1;
    #12;
    checkOutput("reset_count", int'(o_count), 0);
    checkOutput("reset_dst_rdy", int'(dst_rdy), 0);
    checkOutput("reset_aempty", int'(o_aempty), 1);
    checkOutput("reset_afull", int'(o_afull), 0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) doReset();
      applyStimulus(vecs[i].sr, vecs[i].da, vecs[i].fl);
      checkOutput($sformatf("v%0d_src_ack", i), int'(src_ack), vecs[i].exp_sack);
      checkOutput($sformatf("v%0d_wen", i), int'(o_wen), vecs[i].exp_sack);
      checkOutput($sformatf("v%0d_dst_rdy", i), int'(dst_rdy), vecs[i].exp_drdy);
      checkOutput($sformatf("v%0d_ren", i), int'(o_ren), vecs[i].exp_ren);
      checkOutput($sformatf("v%0d_waddr", i), int'(o_waddr), vecs[i].exp_waddr);
      checkOutput($sformatf("v%0d_raddr", i), int'(o_raddr), vecs[i].exp_raddr);
      checkOutput($sformatf("v%0d_count", i), int'(o_count), vecs[i].exp_count);
      checkOutput($sformatf("v%0d_afull", i), int'(o_afull), int'(vecs[i].exp_count >= AFULL));
      checkOutput($sformatf("v%0d_aempty", i), int'(o_aempty), int'(vecs[i].exp_count <= AEMPTY));
    end

    // Test 4a: PASS_FULL=0, full with push+pop requested together
    n = 0;
    do begin
      applyStimulus(1, 0, 0);
      n++;
    end while (o_count != CW'(NDATA) && n < 10);
    checkOutput("t4a_filled", int'(o_count), NDATA);
    applyStimulus(1, 1, 0);
    checkOutput("t4a_src_ack_blocked", int'(src_ack), 0);
    checkOutput("t4a_ren", int'(o_ren), 1);
    applyStimulus(1, 0, 0);
    checkOutput("t4a_count_after_pop", int'(o_count), NDATA - 1);
    checkOutput("t4a_src_ack_next", int'(src_ack), 1);
    applyStimulus(0, 0, 0);
    checkOutput("t4a_refilled", int'(o_count), NDATA);

    // Test 4b: PASS_FULL=1, push accepted alongside a pop on a full FIFO
    for (int k = 0; k < NDATA; k++) applyStimB(1, 0);
    applyStimB(0, 0);
    checkOutput("t4b_filled", int'(count_b), NDATA);
    checkOutput("t4b_afull", int'(afull_b), 1);
    checkOutput("t4b_aempty", int'(aempty_b), 0);
    applyStimB(1, 1);
    checkOutput("t4b_src_ack", int'(src_ack_b), 1);
    checkOutput("t4b_wen", int'(wen_b), 1);
    checkOutput("t4b_ren", int'(ren_b), 1);
    checkOutput("t4b_waddr", int'(waddr_b), 0);
    checkOutput("t4b_raddr", int'(raddr_b), 0);
    applyStimB(0, 0);
    checkOutput("t4b_count_held", int'(count_b), NDATA);
    checkOutput("t4b_waddr_after", int'(waddr_b), 1);
    checkOutput("t4b_raddr_after", int'(raddr_b), 1);
    checkOutput("t4b_dst_rdy", int'(dst_rdy_b), 1);

    // Test 5: streaming at count=2
    doReset();
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 1, 0);
      checkOutput($sformatf("t5_count_%0d", k), int'(o_count), 2);
      checkOutput($sformatf("t5_flags_%0d", k), int'({o_afull, o_aempty}), 0);
      checkOutput($sformatf("t5_hs_%0d", k), int'({src_ack, o_ren}), 3);
    end

    // Test 6: flush at count=3 with both sides active
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("t6_count_before", int'(o_count), 3);
    checkOutput("t6_src_ack", int'(src_ack), 0);
    checkOutput("t6_ren", int'(o_ren), 0);
    checkOutput("t6_dst_rdy", int'(dst_rdy), 0);
    applyStimulus(0, 0, 0);
    checkOutput("t6_count_after", int'(o_count), 0);
    checkOutput("t6_dst_rdy_after", int'(dst_rdy), 0);
    checkOutput("t6_waddr_after", int'(o_waddr), 0);
    checkOutput("t6_raddr_after", int'(o_raddr), 0);

    // Async reset pulse mid-stream, checked before the next clock edge
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    @(posedge i_clk);
    #2;
    checkOutput("t6_pre_rst_count", int'(o_count), 2);
    src_rdy = 1'b0;
    i_rst = 1'b1;
    #1;
    checkOutput("arst_count", int'(o_count), 0);
    checkOutput("arst_dst_rdy", int'(dst_rdy), 0);
    checkOutput("arst_aempty", int'(o_aempty), 1);
    checkOutput("arst_afull", int'(o_afull), 0);
    checkOutput("arst_waddr", int'(o_waddr), 0);
    checkOutput("arst_raddr", int'(o_raddr), 0);
    checkOutput("arst_wen", int'(o_wen), 0);
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    applyStimulus(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
